// File: rtl/led_step_sequencer.sv
// Four-step circular LED sequencer advanced by a button pulse or an auto-step timer.
// Optional SEQ_REVERSE_DIR_EN adds a direction input for stepping backwards.
module led_step_sequencer #(
  parameter int unsigned STEP_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button_pressed,
  input  logic       auto_en,
  input  logic       pause,
`ifdef SEQ_REVERSE_DIR_EN
  input  logic       direction,
`endif
  output logic [1:0] state,
  output logic [3:0] leds,
  output logic       led,
  output logic       step
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } step_e;

  step_e            state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       leds_q, leds_d;
  logic             led_q, led_d;
  logic             step_q, step_d;

  logic             tick;
  logic             adv;
  logic             rev;

`ifdef SEQ_REVERSE_DIR_EN
  assign rev = direction;
`else
  assign rev = 1'b0;
`endif

  // Timer only runs while enabled and unpaused; a tick fires on its last count.
  assign tick = auto_en && !pause && (timer_q == TIMER_LAST);
  // Simultaneous button and tick collapse into a single advance.
  assign adv  = button_pressed | tick;

  always_comb begin
    timer_d = timer_q;
    if (!auto_en) begin
      timer_d = '0;
    end else if (button_pressed) begin
      timer_d = '0;
    end else if (pause) begin
      timer_d = timer_q;
    end else if (tick) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S0;
      timer_q <= '0;
      leds_q  <= 4'b0001;
      led_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      leds_q  <= leds_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (adv) begin
      unique case (state_q)
        S0:      state_d = rev ? S3 : S1;
        S1:      state_d = rev ? S0 : S2;
        S2:      state_d = rev ? S1 : S3;
        S3:      state_d = rev ? S2 : S0;
        default: state_d = S0;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    leds_d = '0;
    led_d  = 1'b0;
    step_d = adv;
    unique case (state_d)
      S0:      leds_d = 4'b0001;
      S1:      leds_d = 4'b0010;
      S2:      leds_d = 4'b0100;
      S3: begin
        leds_d = 4'b1000;
        led_d  = 1'b1;
      end
      default: leds_d = 4'b0001;
    endcase
  end

  assign state = state_q;
  assign leds  = leds_q;
  assign led   = led_q;
  assign step  = step_q;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Scoreboard bench for led_step_sequencer with STEP_CYCLES=4; step strobes are matched
// against queued expectations carrying the cycle they must appear in.
module tb_led_step_sequencer;

  logic       clock;
  logic       reset;
  logic       button_pressed;
  logic       auto_en;
  logic       pause;
  logic       direction;
  logic [1:0] state;
  logic [3:0] leds;
  logic       led;
  logic       step;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic [3:0] leds;
    logic       led;
  } exp_t;

  exp_t exp_q[$];

  led_step_sequencer #(.STEP_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .button_pressed (button_pressed),
    .auto_en        (auto_en),
    .pause          (pause),
`ifdef SEQ_REVERSE_DIR_EN
    .direction      (direction),
`endif
    .state          (state),
    .leds           (leds),
    .led            (led),
    .step           (step)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Expected outputs for each state, written out by hand.
  function automatic exp_t mk(input int c, input logic [1:0] s);
    exp_t e;
    e.cyc = c;
    e.st  = s;
    case (s)
      2'd0: begin e.leds = 4'b0001; e.led = 1'b0; end
      2'd1: begin e.leds = 4'b0010; e.led = 1'b0; end
      2'd2: begin e.leds = 4'b0100; e.led = 1'b0; end
      default: begin e.leds = 4'b1000; e.led = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic expect_step(input int c, input logic [1:0] s);
    exp_q.push_back(mk(c, s));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every step strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (step === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_step actual state=%0d cycle=%0d required no strobe", state, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.cyc || state !== e.st || leds !== e.leds || led !== e.led) begin
          errors++;
          $display("FAIL step_match actual cyc=%0d st=%0d leds=%b led=%b required cyc=%0d st=%0d leds=%b led=%b",
                   cyc, state, leds, led, e.cyc, e.st, e.leds, e.led);
        end
      end
    end else if (step !== 1'b0 && cyc > 1) begin
      checks++;
      errors++;
      $display("FAIL step_unknown actual=%b required 0/1 cycle=%0d", step, cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    reset = 1'b1; button_pressed = 1'b1; auto_en = 1'b0; pause = 1'b0; direction = 1'b0;

    // 1. Reset with button pulses present
    wait_cycles(2);
    check("rst_state", 32'(state), 32'd0);
    check("rst_leds",  32'(leds),  32'b0001);
    check("rst_led",   32'(led),   32'd0);
    check("rst_step",  32'(step),  32'd0);
    reset = 1'b0; button_pressed = 1'b0;
    wait_cycles(2);

    // 2. Manual stepping, timer disabled
    for (int i = 0; i < 4; i++) begin
      button_pressed = 1'b1;
      expect_step(cyc + 1, 2'((i + 1) % 4));
      wait_cycles(1);
      button_pressed = 1'b0;
      wait_cycles(2);
    end
    check("manual_end_state", 32'(state), 32'd0);

    // 3. Auto stepping from reset
    reset = 1'b1; auto_en = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    t = cyc;
    expect_step(t + 4,  2'd1);
    expect_step(t + 8,  2'd2);
    expect_step(t + 12, 2'd3);
    wait_cycles(12);
    check("auto_state", 32'(state), 32'd3);
    check("auto_leds",  32'(leds),  32'b1000);
    auto_en = 1'b0;
    wait_cycles(2);

    // 4. Button coincident with tick: one advance, full period follows
    t = cyc;
    auto_en = 1'b1;
    wait_cycles(3);
    button_pressed = 1'b1;
    expect_step(t + 4, 2'd0);
    expect_step(t + 8, 2'd1);
    wait_cycles(1);
    button_pressed = 1'b0;
    wait_cycles(4);
    check("collide_state", 32'(state), 32'd1);

    // 5. Pause at timer=2 for 10 cycles, then release
    wait_cycles(2);
    pause = 1'b1;
    wait_cycles(10);
    check("pause_hold_state", 32'(state), 32'd1);
    pause = 1'b0;
    expect_step(cyc + 2, 2'd2);
    wait_cycles(2);
    pause = 1'b1;
    wait_cycles(2);
    button_pressed = 1'b1;
    expect_step(cyc + 1, 2'd3);
    wait_cycles(1);
    button_pressed = 1'b0;
    wait_cycles(3);
    auto_en = 1'b0; pause = 1'b0;
    wait_cycles(3);
    check("pause_btn_state", 32'(state), 32'd3);

    // 6. Walk to state 2, then reset with a coincident request
    for (int i = 0; i < 3; i++) begin
      button_pressed = 1'b1;
      expect_step(cyc + 1, 2'(i));
      wait_cycles(1);
      button_pressed = 1'b0;
      wait_cycles(2);
    end
    check("pre_reset_state", 32'(state), 32'd2);
    reset = 1'b1; button_pressed = 1'b1;
    wait_cycles(1);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_step",  32'(step),  32'd0);
    check("midrst_leds",  32'(leds),  32'b0001);
    reset = 1'b0; button_pressed = 1'b0;
    wait_cycles(2);

    // Back-to-back pulses advance every cycle
    button_pressed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_step(cyc + 1, 2'((i + 1) % 4));
      wait_cycles(1);
    end
    button_pressed = 1'b0;
    wait_cycles(2);
    check("b2b_state", 32'(state), 32'd0);

`ifdef SEQ_REVERSE_DIR_EN
    direction = 1'b1;
    for (int i = 0; i < 4; i++) begin
      button_pressed = 1'b1;
      expect_step(cyc + 1, 2'(3 - i));
      wait_cycles(1);
      button_pressed = 1'b0;
      wait_cycles(1);
    end
    direction = 1'b0;
    check("rev_state", 32'(state), 32'd0);
`endif

    wait_cycles(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
